ifid_idex_pipe: RTL and testbench

- Owns the PC register, the IF/ID register and the ID/EX register of the 5-stage MIPS pipeline.
- It is the other end of the Hazard_Unit interface:
  - drives the unit's inputs `mem_read`, `rt1`, `rt2` and `rs1` from its own registers;
  - consumes the unit's outputs `pc_write`, `IFID_write` and `IDEX_zero` to stall or insert bubbles.
- It also applies branch flushes and counts stall cycles for performance debug.

---
 rtl/ifid_idex_pipe.sv | 121 ++++++++++++
 tb/tb_ifid_idex_pipe.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ifid_idex_pipe.sv
// PC, IF/ID and ID/EX registers of the 5-stage MIPS pipeline, driven by the Hazard_Unit's
// stall/bubble controls, with branch flush and a saturating stall-cycle counter.
module ifid_idex_pipe #(
  parameter int unsigned      PC_WIDTH    = 32,
  parameter int unsigned      INSTR_WIDTH = 32,
  parameter int unsigned      CTRL_WIDTH  = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned      CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pc_write,
  input  logic                   IFID_write,
  input  logic                   IDEX_zero,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic [INSTR_WIDTH-1:0] imem_instr,
  input  logic [CTRL_WIDTH-1:0]  id_ctrl,
  input  logic                   id_mem_read,
  input  logic [31:0]            rf_data1,
  input  logic [31:0]            rf_data2,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [INSTR_WIDTH-1:0] ifid_instr,
  output logic [PC_WIDTH-1:0]    ifid_pc4,
  output logic [CTRL_WIDTH-1:0]  idex_ctrl,
  output logic [31:0]            idex_data1,
  output logic [31:0]            idex_data2,
  output logic [31:0]            idex_imm,
  output logic [4:0]             idex_rs,
  output logic [4:0]             idex_rt,
  output logic [4:0]             idex_rd,
  output logic                   mem_read,
  output logic [4:0]             rt1,
  output logic [4:0]             rt2,
  output logic [4:0]             rs1,
  output logic [CNT_WIDTH-1:0]   stall_count
);

  localparam logic [PC_WIDTH-1:0]  PcStep = PC_WIDTH'(4);
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  logic [PC_WIDTH-1:0] pc_plus4;
  logic                idex_mem_read;
  logic [31:0]         imm_ext;

  assign pc_plus4 = pc + PcStep;
  assign imm_ext  = {{16{ifid_instr[15]}}, ifid_instr[15:0]};

  // PC: branch beats pc_write; wraps naturally at PC_WIDTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (branch_taken) begin
      pc <= branch_target;
    end else if (pc_write) begin
      pc <= pc_plus4;
    end
  end

  // IF/ID: branch flush inserts an all-zero NOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_instr <= '0;
      ifid_pc4   <= '0;
    end else if (branch_taken) begin
      ifid_instr <= '0;
      ifid_pc4   <= '0;
    end else if (IFID_write) begin
      ifid_instr <= imem_instr;
      ifid_pc4   <= pc_plus4;
    end
  end

  // ID/EX: no enable; IDEX_zero turns the slot into a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_ctrl     <= '0;
      idex_mem_read <= 1'b0;
      idex_data1    <= '0;
      idex_data2    <= '0;
      idex_imm      <= '0;
      idex_rs       <= '0;
      idex_rt       <= '0;
      idex_rd       <= '0;
    end else if (IDEX_zero) begin
      idex_ctrl     <= '0;
      idex_mem_read <= 1'b0;
      idex_data1    <= '0;
      idex_data2    <= '0;
      idex_imm      <= '0;
      idex_rs       <= '0;
      idex_rt       <= '0;
      idex_rd       <= '0;
    end else begin
      idex_ctrl     <= id_ctrl;
      idex_mem_read <= id_mem_read;
      idex_data1    <= rf_data1;
      idex_data2    <= rf_data2;
      idex_imm      <= imm_ext;
      idex_rs       <= ifid_instr[25:21];
      idex_rt       <= ifid_instr[20:16];
      idex_rd       <= ifid_instr[15:11];
    end
  end

  // Taken-branch cycles are not stalls even when pc_write is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (!pc_write && !branch_taken && (stall_count != CntMax)) begin
      stall_count <= stall_count + CNT_WIDTH'(1);
    end
  end

  // Registered-state only, so no loop forms through the Hazard_Unit.
  assign mem_read = idex_mem_read;
  assign rt1      = idex_rt;
  assign rt2      = ifid_instr[20:16];
  assign rs1      = ifid_instr[25:21];

endmodule

// File: tb/tb_ifid_idex_pipe.sv
// Directed bench for ifid_idex_pipe: free-run, load-use stall, branch flush, sign-extend,
// PC wrap, counter saturation (CNT_WIDTH = 4) and asynchronous reset mid-stall.
module tb_ifid_idex_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write, IFID_write, IDEX_zero, branch_taken;
  logic [31:0] branch_target, imem_instr, rf_data1, rf_data2;
  logic [7:0]  id_ctrl;
  logic        id_mem_read;
  logic [31:0] pc, ifid_instr, ifid_pc4, idex_data1, idex_data2, idex_imm;
  logic [7:0]  idex_ctrl;
  logic [4:0]  idex_rs, idex_rt, idex_rd, rt1, rt2, rs1;
  logic        mem_read;
  logic [3:0]  stall_count;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] I0 = 32'h8C01_0000;  // lw   $1, 0($0)
  localparam logic [31:0] I1 = 32'h0022_1820;  // add  $3, $1, $2
  localparam logic [31:0] I2 = 32'h2085_8001;  // addi $5, $4, 0x8001
  localparam logic [31:0] I3 = 32'h20A6_7FFF;  // addi $6, $5, 0x7fff
  localparam logic [31:0] I4 = 32'h1234_5678;

  ifid_idex_pipe #(
    .PC_WIDTH   (32),
    .INSTR_WIDTH(32),
    .CTRL_WIDTH (8),
    .RESET_PC   (32'h0),
    .CNT_WIDTH  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_write     (pc_write),
    .IFID_write   (IFID_write),
    .IDEX_zero    (IDEX_zero),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_instr   (imem_instr),
    .id_ctrl      (id_ctrl),
    .id_mem_read  (id_mem_read),
    .rf_data1     (rf_data1),
    .rf_data2     (rf_data2),
    .pc           (pc),
    .ifid_instr   (ifid_instr),
    .ifid_pc4     (ifid_pc4),
    .idex_ctrl    (idex_ctrl),
    .idex_data1   (idex_data1),
    .idex_data2   (idex_data2),
    .idex_imm     (idex_imm),
    .idex_rs      (idex_rs),
    .idex_rt      (idex_rt),
    .idex_rd      (idex_rd),
    .mem_read     (mem_read),
    .rt1          (rt1),
    .rt2          (rt2),
    .rs1          (rs1),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    pc_write = 1'b0; IFID_write = 1'b0; IDEX_zero = 1'b0; branch_taken = 1'b0;
    branch_target = '0; imem_instr = '0; id_ctrl = '0; id_mem_read = 1'b0;
    rf_data1 = '0; rf_data2 = '0;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_ifid_instr", ifid_instr, 32'h0);
    chk("rst_idex_ctrl", 32'(idex_ctrl), 32'h0);
    chk("rst_stall", 32'(stall_count), 32'h0);
    #1;
    rst = 1'b0;

    // Free-run
    pc_write = 1'b1; IFID_write = 1'b1; imem_instr = I0;
    step();
    chk("run1_pc", pc, 32'h4);
    chk("run1_ifid", ifid_instr, I0);
    chk("run1_pc4", ifid_pc4, 32'h4);
    imem_instr = I1; id_ctrl = 8'hA5; id_mem_read = 1'b1;
    rf_data1 = 32'h1111_1111; rf_data2 = 32'h2222_2222;
    step();
    chk("run2_pc", pc, 32'h8);
    chk("run2_ifid", ifid_instr, I1);
    chk("run2_pc4", ifid_pc4, 32'h8);
    chk("run2_stall", 32'(stall_count), 32'h0);
    chk("lu_mem_read", 32'(mem_read), 32'h1);
    chk("lu_rt1", 32'(rt1), 32'h1);
    chk("lu_rs1", 32'(rs1), 32'h1);
    chk("lu_rt2", 32'(rt2), 32'h2);
    chk("lu_idex_ctrl", 32'(idex_ctrl), 32'hA5);
    chk("lu_idex_data2", idex_data2, 32'h2222_2222);

    // Load-use stall with bubble
    pc_write = 1'b0; IFID_write = 1'b0; IDEX_zero = 1'b1;
    imem_instr = I2; id_ctrl = 8'h3C; id_mem_read = 1'b0;
    step();
    chk("stall_pc", pc, 32'h8);
    chk("stall_ifid", ifid_instr, I1);
    chk("stall_idex_ctrl", 32'(idex_ctrl), 32'h0);
    chk("stall_mem_read", 32'(mem_read), 32'h0);
    chk("stall_idex_data1", idex_data1, 32'h0);
    chk("stall_count1", 32'(stall_count), 32'h1);

    // Release: add enters ID/EX
    pc_write = 1'b1; IFID_write = 1'b1; IDEX_zero = 1'b0; rf_data1 = 32'h3333_3333;
    step();
    chk("rel_pc", pc, 32'hC);
    chk("rel_ifid", ifid_instr, I2);
    chk("rel_pc4", ifid_pc4, 32'hC);
    chk("rel_idex_rs", 32'(idex_rs), 32'h1);
    chk("rel_idex_rt", 32'(idex_rt), 32'h2);
    chk("rel_idex_rd", 32'(idex_rd), 32'h3);
    chk("rel_idex_ctrl", 32'(idex_ctrl), 32'h3C);
    chk("rel_idex_data1", idex_data1, 32'h3333_3333);
    chk("rel_idex_imm", idex_imm, 32'h0000_1820);
    chk("rel_stall", 32'(stall_count), 32'h1);

    imem_instr = I3; id_ctrl = 8'h0F;
    step();
    chk("sx_neg_pc", pc, 32'h10);
    chk("sx_neg_imm", idex_imm, 32'hFFFF_8001);
    chk("sx_neg_rs", 32'(idex_rs), 32'h4);

    // Taken branch with pc_write low
    branch_taken = 1'b1; branch_target = 32'h40; pc_write = 1'b0; imem_instr = I4;
    step();
    chk("br_pc", pc, 32'h40);
    chk("br_ifid", ifid_instr, 32'h0);
    chk("br_pc4", ifid_pc4, 32'h0);
    chk("sx_pos_imm", idex_imm, 32'h0000_7FFF);
    chk("br_idex_rt", 32'(idex_rt), 32'h6);
    chk("br_stall", 32'(stall_count), 32'h1);

    // PC wrap
    branch_target = 32'hFFFF_FFFC; pc_write = 1'b1;
    step();
    chk("wrap_pre_pc", pc, 32'hFFFF_FFFC);
    branch_taken = 1'b0; imem_instr = I0;
    step();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_pc4", ifid_pc4, 32'h0);
    chk("wrap_ifid", ifid_instr, I0);

    branch_taken = 1'b1; branch_target = 32'h80; pc_write = 1'b0;
    step();
    chk("br2_pc", pc, 32'h80);
    branch_taken = 1'b0; pc_write = 1'b1; imem_instr = I1;
    step();
    chk("pre_sat_pc", pc, 32'h84);
    chk("pre_sat_stall", 32'(stall_count), 32'h1);

    // Long stall: counter saturates at 15
    pc_write = 1'b0; IFID_write = 1'b0; id_ctrl = 8'h5A; id_mem_read = 1'b1;
    for (int i = 0; i < 13; i++) step();
    chk("sat_14", 32'(stall_count), 32'hE);
    for (int i = 0; i < 7; i++) step();
    chk("sat_15", 32'(stall_count), 32'hF);
    chk("sat_pc", pc, 32'h84);
    chk("sat_ifid", ifid_instr, I1);
    chk("sat_mem_read", 32'(mem_read), 32'h1);

    // Asynchronous reset between edges
    #3;
    rst = 1'b1;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_ifid", ifid_instr, 32'h0);
    chk("arst_pc4", ifid_pc4, 32'h0);
    chk("arst_stall", 32'(stall_count), 32'h0);
    chk("arst_idex_ctrl", 32'(idex_ctrl), 32'h0);
    chk("arst_mem_read", 32'(mem_read), 32'h0);
    step();
    chk("arst_hold_pc", pc, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
